scan_mem_loader: RTL and testbench

- Parametrised scan-chain memory port that replaces the fixed write-only IMEM scan loader.
- Deserialises a scan_in bitstream into a command header, then either writes a burst of words to a memory port or reads a burst back out on scan_out.
- Sits between the tester pins (scan_en / scan_in / scan_out) and the IMEM/DMEM write/read port.
- Holds the core in reset while a transfer is in progress.

---
 rtl/scan_mem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_scan_mem_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : scan_mem_loader
// Purpose  : Scan-chain memory port. Deserialises a command header from
//            scan_in, then writes a burst of words to memory or reads a burst
//            back out on scan_out. Holds the core in reset while busy.
// Revision : 1.0 - initial release
// ============================================================================
module scan_mem_loader #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 32,
    parameter int ADDR_INC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
    output logic              scan_out_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              core_hold,
    output logic              done,
    output logic              overrun
);

    localparam int c_MAX_W = (DATA_W > ADDR_W) ? ((DATA_W > LEN_W) ? DATA_W : LEN_W)
                                               : ((ADDR_W > LEN_W) ? ADDR_W : LEN_W);
    localparam int c_CNT_W = $clog2(c_MAX_W);
    localparam logic [c_CNT_W-1:0] c_LEN_LAST  = c_CNT_W'(LEN_W - 1);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,   // command bit taken, collecting length field
        S_ADDR = 3'd2,
        S_WR   = 3'd3,
        S_RD   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_cmd;
    logic [LEN_W-1:0]    r_len;
    logic [ADDR_W-2:0]   r_addr_sh;
    logic [DATA_W-2:0]   r_wsh;
    logic [DATA_W-1:0]   r_osh;
    logic [LEN_W-1:0]    r_remaining;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_req;
    logic                r_we;
    logic                r_sov;
    logic                r_done;
    logic                r_overrun;

    // The final bit of a field arrives on scan_in, so full values combine
    // it with the bits already shifted in.
    logic                w_abort;
    logic                w_accept;
    logic                w_last_word;
    logic                w_rd_bit_last;
    logic [ADDR_W-1:0]   w_addr_full;
    logic [DATA_W-1:0]   w_word_full;

    assign w_abort       = (r_state != S_IDLE) && !scan_en;
    assign w_accept      = r_req && mem_ready;
    assign w_last_word   = (r_remaining == LEN_W'(1));
    assign w_rd_bit_last = r_sov && (r_cnt == c_DATA_LAST);
    assign w_addr_full   = {scan_in, r_addr_sh};
    assign w_word_full   = {scan_in, r_wsh};

    // Next-state selection; dropping scan_en anywhere but IDLE aborts.
    always_comb begin
        w_state_nxt = r_state;
        if (w_abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (scan_en) w_state_nxt = S_CMD;
                S_CMD:  if (r_cnt == c_LEN_LAST) w_state_nxt = S_ADDR;
                S_ADDR: if (r_cnt == c_ADDR_LAST)
                            w_state_nxt = (r_len == '0) ? S_DONE : (r_cmd ? S_WR : S_RD);
                S_WR:   if (w_accept && w_last_word) w_state_nxt = S_DONE;
                S_RD:   if (w_rd_bit_last && w_last_word) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Header deserialisation, write/read burst datapath and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_cmd       <= 1'b0;
            r_len       <= '0;
            r_addr_sh   <= '0;
            r_wsh       <= '0;
            r_osh       <= '0;
            r_remaining <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_sov       <= 1'b0;
            r_done      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == S_DONE) && (r_state != S_DONE);
            if (w_abort) begin
                r_cnt <= '0;
                r_req <= 1'b0;
                r_we  <= 1'b0;
                r_sov <= 1'b0;
                r_osh <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (scan_en) begin
                            r_cmd <= scan_in;
                            r_cnt <= '0;
                        end
                    end
                    S_CMD: begin
                        r_len <= {scan_in, r_len[LEN_W-1:1]};
                        r_cnt <= (r_cnt == c_LEN_LAST) ? '0 : r_cnt + c_CNT_W'(1);
                    end
                    S_ADDR: begin
                        r_addr_sh <= {scan_in, r_addr_sh[ADDR_W-2:1]};
                        r_cnt     <= (r_cnt == c_ADDR_LAST) ? '0 : r_cnt + c_CNT_W'(1);
                        if ((r_cnt == c_ADDR_LAST) && (r_len != '0)) begin
                            r_addr      <= w_addr_full;
                            r_remaining <= r_len;
                            r_req       <= !r_cmd;   // reads issue immediately
                            r_we        <= 1'b0;
                        end
                    end
                    S_WR: begin
                        r_wsh <= {scan_in, r_wsh[DATA_W-2:1]};
                        r_cnt <= (r_cnt == c_DATA_LAST) ? '0 : r_cnt + c_CNT_W'(1);
                        if (w_accept) begin
                            r_req       <= 1'b0;
                            r_we        <= 1'b0;
                            r_addr      <= r_addr + ADDR_W'(ADDR_INC);
                            r_remaining <= r_remaining - LEN_W'(1);
                        end
                        // A word that completes while the previous one is
                        // still waiting is dropped and flagged.
                        if (r_cnt == c_DATA_LAST) begin
                            if (r_req && !mem_ready) begin
                                r_overrun <= 1'b1;
                            end else if (!(w_accept && w_last_word)) begin
                                r_wdata <= w_word_full;
                                r_req   <= 1'b1;
                                r_we    <= 1'b1;
                            end
                        end
                    end
                    S_RD: begin
                        if (w_accept) begin
                            r_req <= 1'b0;
                            r_osh <= mem_rdata;
                            r_sov <= 1'b1;
                            r_cnt <= '0;
                        end else if (r_sov) begin
                            r_osh <= {1'b0, r_osh[DATA_W-1:1]};
                            r_cnt <= (r_cnt == c_DATA_LAST) ? '0 : r_cnt + c_CNT_W'(1);
                            if (r_cnt == c_DATA_LAST) begin
                                r_sov       <= 1'b0;
                                r_addr      <= r_addr + ADDR_W'(ADDR_INC);
                                r_remaining <= r_remaining - LEN_W'(1);
                                r_req       <= !w_last_word;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign scan_out       = r_sov & r_osh[0];
    assign scan_out_valid = r_sov;
    assign mem_req        = r_req;
    assign mem_we         = r_we;
    assign mem_addr       = r_addr;
    assign mem_wdata      = r_wdata;
    assign core_hold      = (r_state != S_IDLE);
    assign done           = r_done;
    assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_scan_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_mem_loader
// Purpose  : Self-checking bench for scan_mem_loader. A transaction-level
//            model (expected write queue, expected read addresses, expected
//            scan_out bit stream, model memory) is checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_mem_loader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_en = 1'b0;
    logic          scan_in = 1'b0;
    logic          scan_out, scan_out_valid, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          core_hold, done, overrun;

    always #5 clk = ~clk;

    scan_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .ADDR_INC(4)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out), .scan_out_valid(scan_out_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .core_hold(core_hold), .done(done), .overrun(overrun)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_ra[$];
    logic        exp_bits[$];
    logic [31:0] mem_model[logic [31:0]];
    logic [31:0] wbuf[8];
    logic [63:0] rd_shadow = '0;

    int rd_delay   = 0;
    int wait_cnt   = 0;
    int done_cnt   = 0;
    int req_cycles = 0;
    int sov_cnt    = 0;
    int d0, rc0, s0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Memory responder and per-cycle compare against the model queues.
    always @(negedge clk) begin : compare
        logic b;
        logic [31:0] ea, ed;
        if (!rst_n) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else begin
            if (mem_req) begin
                mem_ready = (wait_cnt >= rd_delay);
                wait_cnt++;
                req_cycles++;
                mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    if (exp_wa.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", mem_addr, mem_wdata);
                    end else begin
                        ea = exp_wa.pop_front();
                        ed = exp_wd.pop_front();
                        check("write_addr", mem_addr, ea);
                        check("write_data", mem_wdata, ed);
                    end
                end else begin
                    if (exp_ra.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_read: got addr 0x%0h, expected none", mem_addr);
                    end else begin
                        ea = exp_ra.pop_front();
                        check("read_addr", mem_addr, ea);
                    end
                end
            end
            if (scan_out_valid) begin
                sov_cnt++;
                rd_shadow = {scan_out, rd_shadow[63:1]};
                if (exp_bits.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_scan_bit: got %0b, expected no valid bit", scan_out);
                end else begin
                    b = exp_bits.pop_front();
                    check("scan_out_bit", scan_out, b);
                end
            end else begin
                check("scan_out_idle", scan_out, 1'b0);
            end
            if (done) done_cnt++;
        end
    end

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_en = 1'b1;
            scan_in = v[i];
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_en = 1'b1;
            scan_in = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_en = 1'b0;
            scan_in = 1'b0;
        end
    endtask

    task automatic header(input logic cmd, input logic [31:0] len, input logic [31:0] addr);
        send_bits({63'd0, cmd}, 1);
        send_bits({32'd0, len}, LW);
        send_bits({32'd0, addr}, AW);
    endtask

    // Write header, then send nwords from wbuf, expecting each at addr+4*i.
    task automatic send_write(input logic [31:0] addr, input logic [31:0] len, input int nwords);
        header(1'b1, len, addr);
        for (int i = 0; i < nwords; i++) begin
            exp_wa.push_back(addr + 32'(4 * i));
            exp_wd.push_back(wbuf[i]);
            send_bits({32'd0, wbuf[i]}, DW);
        end
    endtask

    task automatic fill_wbuf();
        for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    endtask

    task automatic write_burst(input logic [31:0] addr, input int len, input int delay);
        rd_delay = delay;
        d0 = done_cnt;
        fill_wbuf();
        send_write(addr, 32'(len), len);
        hold(delay + 8);
        check("wr_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("wr_all_written", 64'(exp_wa.size()), 64'd0);
        idle(3);
        check("wr_core_hold_idle", core_hold, 1'b0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input int len, input int delay);
        logic [31:0] a, w;
        rd_delay = delay;
        for (int i = 0; i < len; i++) begin
            a = addr + 32'(4 * i);
            if (!mem_model.exists(a)) mem_model[a] = $urandom;
            w = mem_model[a];
            exp_ra.push_back(a);
            for (int k = 0; k < DW; k++) exp_bits.push_back(w[k]);
        end
        d0 = done_cnt;
        s0 = sov_cnt;
        rd_shadow = '0;
        header(1'b0, 32'(len), addr);
        hold(len * (delay + 36) + 6);
        check("rd_valid_edges", 64'(sov_cnt - s0), 64'(len * DW));
        check("rd_bits_left", 64'(exp_bits.size()), 64'd0);
        check("rd_reads_left", 64'(exp_ra.size()), 64'd0);
        check("rd_done_pulses", 64'(done_cnt - d0), 64'd1);
        idle(3);
        check("rd_core_hold_idle", core_hold, 1'b0);
    endtask

    initial begin : stim
        logic [31:0] a;
        int          l, dl;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_flags", {mem_we, scan_out, scan_out_valid, core_hold, done, overrun}, 6'b0);
        rst_n = 1'b1;

        // Write burst, mem_ready immediate; pins the latency
        rd_delay = 0;
        d0 = done_cnt;
        wbuf[0] = 32'h00012117;
        wbuf[1] = 32'h04010113;
        send_write(32'h0, 32'd2, 2);
        @(negedge clk);
        check("lat_mem_req", mem_req, 1'b1);
        check("lat_mem_we", mem_we, 1'b1);
        check("lat_mem_addr", mem_addr, 32'h4);
        check("lat_mem_wdata", mem_wdata, 32'h04010113);
        hold(4);
        check("t1_core_hold_done", core_hold, 1'b1);
        check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t1_all_written", 64'(exp_wa.size()), 64'd0);
        idle(2);
        check("t1_core_hold_idle", core_hold, 1'b0);

        // Read-back with 3-cycle memory latency
        mem_model[32'h8] = 32'hDEADBEEF;
        mem_model[32'hC] = 32'h12345678;
        read_burst(32'h8, 2, 3);
        check("t2_stream", rd_shadow, 64'h12345678_DEADBEEF);

        // Abort after 3 words of a huge burst
        rd_delay = 0;
        d0 = done_cnt;
        fill_wbuf();
        send_write(32'h0, 32'hFFFFFFFF, 3);
        hold(3);
        idle(3);
        check("t3_core_hold_idle", core_hold, 1'b0);
        check("t3_no_done", 64'(done_cnt - d0), 64'd0);
        check("t3_all_written", 64'(exp_wa.size()), 64'd0);

        // Length 0: done without any memory request
        d0 = done_cnt;
        rc0 = req_cycles;
        header(1'b1, 32'd0, $urandom);
        hold(3);
        check("t4_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t4_no_req", 64'(req_cycles - rc0), 64'd0);
        check("t4_core_hold_done", core_hold, 1'b1);
        idle(2);

        // Address wrap
        write_burst(32'hFFFFFFFC, 2, 1);

        // Randomized bursts
        for (int it = 0; it < 8; it++) begin
            a  = $urandom;
            dl = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) begin
                l = $urandom_range(1, 4);
                write_burst(a, l, dl);
            end else begin
                l = $urandom_range(1, 3);
                read_burst(a, l, dl);
            end
        end

        // Overrun: second word arrives while the first is still pending
        rd_delay = 40;
        d0 = done_cnt;
        fill_wbuf();
        exp_wa.push_back(32'h100);
        exp_wd.push_back(wbuf[0]);
        header(1'b1, 32'd2, 32'h100);
        send_bits({32'd0, wbuf[0]}, DW);
        send_bits({32'd0, wbuf[1]}, DW);
        @(negedge clk);
        check("t7_overrun_set", overrun, 1'b1);
        check("t7_pending_req", mem_req, 1'b1);
        check("t7_pending_data", mem_wdata, wbuf[0]);
        hold(15);
        check("t7_first_written", 64'(exp_wa.size()), 64'd0);
        check("t7_still_busy", core_hold, 1'b1);
        check("t7_no_done", 64'(done_cnt - d0), 64'd0);
        idle(3);
        write_burst($urandom, 1, 0);
        check("t7_overrun_sticky", overrun, 1'b1);

        // Asynchronous reset mid-burst
        rd_delay = 40;
        fill_wbuf();
        header(1'b1, 32'd2, 32'h200);
        send_bits({32'd0, wbuf[0]}, DW);
        @(negedge clk);
        check("t8_pre_req", mem_req, 1'b1);
        check("t8_pre_hold", core_hold, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t8_async_req", mem_req, 1'b0);
        check("t8_async_addr", mem_addr, 32'h0);
        check("t8_async_wdata", mem_wdata, 32'h0);
        check("t8_async_flags", {mem_we, scan_out_valid, core_hold, done, overrun}, 5'b0);
        scan_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Normal operation after reset, overrun cleared
        write_burst($urandom, 2, 0);
        check("t8_overrun_clear", overrun, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
